decode_stage_pipelined: RTL and testbench

- Parametrised next-generation instruction decode stage: register file with write-through bypass, RV32I immediate generation, field extraction, and a registered ID/EX pipeline boundary with stall and flush.
- Sits between the fetch stage (IF/ID outputs) and the execute stage. Writeback from the last stage feeds back into it.

---
 rtl/decode_stage_pipelined.sv | 127 ++++++++++++
 tb/tb_decode_stage_pipelined.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipelined.sv
// Instruction decode stage: register file with write-through bypass, RV32I immediate
// generation, field extraction and a registered ID/EX boundary with stall and flush.
module decode_stage_pipelined #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_IDX_W = 5,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inValid,
  input  logic [31:0]          instruction,
  input  logic [XLEN-1:0]      pc,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 writeBackEnable,
  input  logic [REG_IDX_W-1:0] writeBackIndex,
  input  logic [XLEN-1:0]      writeBackData,
  output logic                 outValid,
  output logic [XLEN-1:0]      outPc,
  output logic [XLEN-1:0]      LHSRegisterValue,
  output logic [XLEN-1:0]      RHSRegisterValue,
  output logic [XLEN-1:0]      immediate,
  output logic [REG_IDX_W-1:0] rdIndex,
  output logic [REG_IDX_W-1:0] rs1Index,
  output logic [REG_IDX_W-1:0] rs2Index,
  output logic [6:0]           opcode,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic                 illegalRegister
);

  logic [XLEN-1:0]      r_regs [NUM_REGS];
  logic [REG_IDX_W-1:0] w_rdIdx;
  logic [REG_IDX_W-1:0] w_rs1Idx;
  logic [REG_IDX_W-1:0] w_rs2Idx;
  logic [XLEN-1:0]      w_rs1Val;
  logic [XLEN-1:0]      w_rs2Val;
  logic [31:0]          w_imm32;
  logic [XLEN-1:0]      w_immediate;
  logic                 w_illegal;
  logic                 w_wbAllowed;

  assign w_rdIdx  = instruction[7 +: REG_IDX_W];
  assign w_rs1Idx = instruction[15 +: REG_IDX_W];
  assign w_rs2Idx = instruction[20 +: REG_IDX_W];

  assign w_wbAllowed = writeBackEnable && !((ZERO_REG != 0) && (writeBackIndex == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wbAllowed) begin
      r_regs[writeBackIndex] <= writeBackData;
    end
  end

  // Same-cycle writeback is forwarded so a capture never sees a stale operand.
  always_comb begin
    w_rs1Val = r_regs[w_rs1Idx];
    if ((ZERO_REG != 0) && (w_rs1Idx == '0)) w_rs1Val = '0;
    else if (w_wbAllowed && (writeBackIndex == w_rs1Idx)) w_rs1Val = writeBackData;
  end

  always_comb begin
    w_rs2Val = r_regs[w_rs2Idx];
    if ((ZERO_REG != 0) && (w_rs2Idx == '0)) w_rs2Val = '0;
    else if (w_wbAllowed && (writeBackIndex == w_rs2Idx)) w_rs2Val = writeBackData;
  end

  always_comb begin
    w_imm32 = '0;
    case (instruction[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
      7'b0100011:
        w_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      7'b1100011:
        w_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        w_imm32 = {instruction[31:12], 12'b0};
      7'b1101111:
        w_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      default:
        w_imm32 = '0;
    endcase
  end

  // Extend from bit 31 so the same expression serves XLEN of 32 and 64.
  assign w_immediate = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

  assign w_illegal = (NUM_REGS == 16) && inValid &&
                     (instruction[11] || instruction[19] || instruction[24]);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      outValid         <= 1'b0;
      outPc            <= '0;
      LHSRegisterValue <= '0;
      RHSRegisterValue <= '0;
      immediate        <= '0;
      rdIndex          <= '0;
      rs1Index         <= '0;
      rs2Index         <= '0;
      opcode           <= '0;
      funct3           <= '0;
      funct7           <= '0;
      illegalRegister  <= 1'b0;
    end else if (!stall) begin
      outValid         <= inValid;
      outPc            <= pc;
      LHSRegisterValue <= w_rs1Val;
      RHSRegisterValue <= w_rs2Val;
      immediate        <= w_immediate;
      rdIndex          <= w_rdIdx;
      rs1Index         <= w_rs1Idx;
      rs2Index         <= w_rs2Idx;
      opcode           <= instruction[6:0];
      funct3           <= instruction[14:12];
      funct7           <= instruction[31:25];
      illegalRegister  <= w_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed self-checking bench for decode_stage_pipelined with hand-computed expectations.
module tb_decode_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        writeBackEnable;
  logic [4:0]  writeBackIndex;
  logic [31:0] writeBackData;
  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] LHSRegisterValue;
  logic [31:0] RHSRegisterValue;
  logic [31:0] immediate;
  logic [4:0]  rdIndex;
  logic [4:0]  rs1Index;
  logic [4:0]  rs2Index;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        illegalRegister;

  int testsRun = 0;
  int testsFailed = 0;

  decode_stage_pipelined #(
    .XLEN(32), .NUM_REGS(32), .REG_IDX_W(5), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .instruction(instruction), .pc(pc),
    .stall(stall), .flush(flush), .writeBackEnable(writeBackEnable),
    .writeBackIndex(writeBackIndex), .writeBackData(writeBackData),
    .outValid(outValid), .outPc(outPc), .LHSRegisterValue(LHSRegisterValue),
    .RHSRegisterValue(RHSRegisterValue), .immediate(immediate), .rdIndex(rdIndex),
    .rs1Index(rs1Index), .rs2Index(rs2Index), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .illegalRegister(illegalRegister)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the rising edge capture them, then settle off-edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic [31:0] instr,
                               input logic [31:0] pcIn, input logic stl, input logic fls,
                               input logic wbEn, input logic [4:0] wbIdx,
                               input logic [31:0] wbData);
    reset           = rst;
    inValid         = vld;
    instruction     = instr;
    pc              = pcIn;
    stall           = stl;
    flush           = fls;
    writeBackEnable = wbEn;
    writeBackIndex  = wbIdx;
    writeBackData   = wbData;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; instruction = '0; pc = '0; stall = 1'b0; flush = 1'b0;
    writeBackEnable = 1'b0; writeBackIndex = '0; writeBackData = '0;

    // Reset holds everything at zero even with a valid instruction presented
    applyStimulus(1, 1, 32'h002081B3, 32'h100, 0, 0, 0, 5'd0, 32'h0);
    applyStimulus(1, 1, 32'h002081B3, 32'h100, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("resetValid", 64'(outValid), 64'd0);
    checkOutput("resetPc", 64'(outPc), 64'd0);
    checkOutput("resetOpcode", 64'(opcode), 64'd0);
    checkOutput("resetRd", 64'(rdIndex), 64'd0);

    // add x3,x1,x2 after reset: empty register file
    applyStimulus(0, 1, 32'h002081B3, 32'h100, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("addValid", 64'(outValid), 64'd1);
    checkOutput("addPc", 64'(outPc), 64'h100);
    checkOutput("addLhs", 64'(LHSRegisterValue), 64'd0);
    checkOutput("addRhs", 64'(RHSRegisterValue), 64'd0);
    checkOutput("addRd", 64'(rdIndex), 64'd3);
    checkOutput("addRs1", 64'(rs1Index), 64'd1);
    checkOutput("addRs2", 64'(rs2Index), 64'd2);
    checkOutput("addOpcode", 64'(opcode), 64'h33);
    checkOutput("addImm", 64'(immediate), 64'd0);
    checkOutput("addIllegal", 64'(illegalRegister), 64'd0);

    // Write x1 and x2, then read them back
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 5'd1, 32'hDEADBEEF);
    checkOutput("bubbleValid", 64'(outValid), 64'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 5'd2, 32'h5);
    applyStimulus(0, 1, 32'h002081B3, 32'h104, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("wrLhs", 64'(LHSRegisterValue), 64'hDEADBEEF);
    checkOutput("wrRhs", 64'(RHSRegisterValue), 64'h5);

    // addi x5,x1,-1 with x1 written in the same cycle
    applyStimulus(0, 1, 32'hFFF08293, 32'h108, 0, 0, 1, 5'd1, 32'h12345678);
    checkOutput("bypLhs", 64'(LHSRegisterValue), 64'h12345678);
    checkOutput("bypImm", 64'(immediate), 64'hFFFFFFFF);
    checkOutput("bypRd", 64'(rdIndex), 64'd5);
    checkOutput("bypOpcode", 64'(opcode), 64'h13);

    // x0 is neither bypassed nor written
    applyStimulus(0, 1, 32'h00000013, 32'h10C, 0, 0, 1, 5'd0, 32'hFFFF);
    checkOutput("x0Bypass", 64'(LHSRegisterValue), 64'd0);
    applyStimulus(0, 1, 32'h00000013, 32'h110, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("x0Stored", 64'(LHSRegisterValue), 64'd0);

    // Immediate formats
    applyStimulus(0, 1, 32'hFE20AE23, 32'h114, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("swImm", 64'(immediate), 64'hFFFFFFFC);
    checkOutput("swFunct3", 64'(funct3), 64'd2);
    checkOutput("swFunct7", 64'(funct7), 64'h7F);
    applyStimulus(0, 1, 32'h00208463, 32'h118, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("beqImm", 64'(immediate), 64'd8);
    applyStimulus(0, 1, 32'h123450B7, 32'h11C, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("luiImm", 64'(immediate), 64'h12345000);
    applyStimulus(0, 1, 32'hFFDFF06F, 32'h120, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("jalImm", 64'(immediate), 64'hFFFFFFFC);

    // Load A, then stall while B waits and x1 is rewritten
    applyStimulus(0, 1, 32'h002081B3, 32'h200, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("loadAPc", 64'(outPc), 64'h200);
    checkOutput("loadALhs", 64'(LHSRegisterValue), 64'h12345678);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'hFFF08293, 32'h204, 1, 0, (i == 0), 5'd1, 32'hAAAA);
      checkOutput("stallPc", 64'(outPc), 64'h200);
      checkOutput("stallOpcode", 64'(opcode), 64'h33);
      checkOutput("stallLhs", 64'(LHSRegisterValue), 64'h12345678);
    end
    applyStimulus(0, 1, 32'hFFF08293, 32'h204, 1, 1, 0, 5'd0, 32'h0);
    checkOutput("flushValid", 64'(outValid), 64'd0);
    checkOutput("flushPc", 64'(outPc), 64'd0);
    checkOutput("flushOpcode", 64'(opcode), 64'd0);
    checkOutput("flushLhs", 64'(LHSRegisterValue), 64'd0);
    applyStimulus(0, 1, 32'hFFF08293, 32'h204, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("relValid", 64'(outValid), 64'd1);
    checkOutput("relPc", 64'(outPc), 64'h204);
    checkOutput("relLhs", 64'(LHSRegisterValue), 64'hAAAA);
    checkOutput("relImm", 64'(immediate), 64'hFFFFFFFF);

    // Invalid input still captures fields but outValid follows inValid
    applyStimulus(0, 0, 32'h002081B3, 32'h208, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("invValid", 64'(outValid), 64'd0);
    checkOutput("invRd", 64'(rdIndex), 64'd3);

    // Mid-run reset wipes the register file
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
    applyStimulus(0, 1, 32'h002081B3, 32'h300, 0, 0, 0, 5'd0, 32'h0);
    checkOutput("rstLhs", 64'(LHSRegisterValue), 64'd0);
    checkOutput("rstRhs", 64'(RHSRegisterValue), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
